// File: rtl/div_hilo_seq_pkg.sv
//==============================================================================
// Module      : hilo_pkg
// Description : Shared types and constants for the HI/LO divide sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hilo_pkg;

    // Default cycles from core launch to stable core results
    localparam int          CORE_LAT_DEF = 34;

    // Most negative 32-bit value; the only dividend whose signed quotient overflows
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FIX    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/div_hilo_seq_if.sv
//==============================================================================
// Module      : div_hilo_seq_if
// Description : Control-unit side bundle of the HI/LO divide sequencer:
//               division request, flush, MTHI/MTLO writes and the HI/LO,
//               busy, done and div_zero status returned to control.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface div_hilo_seq_if;

    logic        start;
    logic        is_signed;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    // Control unit side
    modport master (
        output start, is_signed, rs_val, rt_val, flush, mthi_we, mtlo_we, wdata,
        input  hi, lo, busy, done, div_zero
    );

    // Sequencer side
    modport slave (
        input  start, is_signed, rs_val, rt_val, flush, mthi_we, mtlo_we, wdata,
        output hi, lo, busy, done, div_zero
    );

endinterface

`default_nettype wire

// File: rtl/div_hilo_seq_sign_fix.sv
//==============================================================================
// Module      : sign_fix
// Description : Conditional two's-complement negate of a 32-bit value.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sign_fix (
    input  wire logic [31:0] in_i,
    input  wire logic        en_i,
    output logic      [31:0] out_o
);

    // Negate when enabled, pass through otherwise
    assign out_o = en_i ? (~in_i + 32'd1) : in_i;

endmodule

`default_nettype wire

// File: rtl/div_hilo_seq.sv
//==============================================================================
// Module      : div_hilo_seq
// Description : Sequencer between control and the unsigned divider core.
//               Converts operands to magnitudes, launches the core, waits
//               CORE_LAT cycles, sign-corrects and commits HI/LO. Also
//               serves MTHI/MTLO. Signed DIV support is built only when the
//               macro DIV_SIGNED_EN is defined; otherwise all requests are
//               handled as DIVU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_hilo_seq
    import hilo_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    div_hilo_seq_if.slave    bus,
    output logic      [31:0] core_n,
    output logic      [31:0] core_d,
    output logic             core_init,
    output logic             core_stop,
    input  wire logic [31:0] core_hi,
    input  wire logic [31:0] core_lo
);

    localparam int CNT_W = $clog2(CORE_LAT + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic [31:0]      n_mag_d;
    logic [31:0]      d_mag_d;
    logic [31:0]      lo_fix_d;
    logic [31:0]      hi_fix_d;

`ifdef DIV_SIGNED_EN
    logic quo_neg_q;
    logic rem_neg_q;
    logic quo_neg_d;
    logic rem_neg_d;

    assign quo_neg_d = bus.is_signed & (bus.rs_val[31] ^ bus.rt_val[31]);
    assign rem_neg_d = bus.is_signed & bus.rs_val[31];

    sign_fix u_n_mag (.in_i(bus.rs_val), .en_i(rem_neg_d),                        .out_o(n_mag_d));
    sign_fix u_d_mag (.in_i(bus.rt_val), .en_i(bus.is_signed & bus.rt_val[31]),   .out_o(d_mag_d));
    sign_fix u_lo_fix(.in_i(core_lo),    .en_i(quo_neg_q),                        .out_o(lo_fix_d));
    sign_fix u_hi_fix(.in_i(core_hi),    .en_i(rem_neg_q),                        .out_o(hi_fix_d));
`else
    // Unsigned-only build: operands and results pass straight through
    logic w_unused_sgn;
    assign w_unused_sgn = bus.is_signed;
    assign n_mag_d      = bus.rs_val;
    assign d_mag_d      = bus.rt_val;
    assign lo_fix_d     = core_lo;
    assign hi_fix_d     = core_hi;
`endif

    // Sequencer FSM: accept, launch, wait out the core latency, commit or abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            core_n     <= '0;
            core_d     <= '0;
            core_init  <= 1'b0;
            core_stop  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            core_init  <= 1'b0;
            core_stop  <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Moves land even alongside a start; the division overwrites later
                    if (bus.mthi_we) hi_q <= bus.wdata;
                    if (bus.mtlo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        if (bus.rt_val == 32'd0) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            core_n    <= n_mag_d;
                            core_d    <= d_mag_d;
`ifdef DIV_SIGNED_EN
                            quo_neg_q <= quo_neg_d;
                            rem_neg_q <= rem_neg_d;
`endif
                            core_init <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    if (bus.flush) begin
                        core_stop <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q   <= CNT_W'(CORE_LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        core_stop <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    // Flush wins over the commit
                    if (bus.flush) begin
                        core_stop <= 1'b1;
                    end else begin
                        hi_q   <= hi_fix_d;
                        lo_q   <= lo_fix_d;
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

`default_nettype wire
